// File: rtl/stack_lifo_ctrl.sv
// Parametrised LIFO stack: internal stack pointer, full/empty/count, replace-top push+pop,
// sticky overflow/underflow. Define STACK_PEEK_EN to add the combinational TopData output.
module stack_lifo_ctrl #(
   parameter int  DATA_W = 4,
   parameter int  DEPTH  = 8,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              PushEnbl,
   input  logic              PopEnbl,
   input  logic [DATA_W-1:0] PushDataIn,
   input  logic              ClrErr,
   output logic [DATA_W-1:0] PopDataOut,
   output logic              PopValid,
   output logic              Stack_Full,
   output logic              Stack_Empty,
   output logic [CNT_W-1:0]  Count,
`ifdef STACK_PEEK_EN
   output logic [DATA_W-1:0] TopData,
`endif
   output logic              Overflow,
   output logic              Underflow
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_pop_data;
   logic              r_pop_valid;
   logic              r_ovf;
   logic              r_udf;

   logic              w_full;
   logic              w_empty;
   logic              w_push_ok;
   logic              w_pop_ok;
   logic              w_ovf_set;
   logic              w_udf_set;
   logic [AW-1:0]     w_rd_addr;
   logic [AW-1:0]     w_wr_addr;
   logic [CNT_W-1:0]  w_count_next;

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_empty   = (r_count == '0);
   // A push while full is only accepted together with a pop (replace-top).
   assign w_push_ok = PushEnbl & (~w_full | PopEnbl);
   assign w_pop_ok  = PopEnbl & ~w_empty;
   assign w_ovf_set = PushEnbl & ~PopEnbl & w_full;
   assign w_udf_set = PopEnbl & w_empty;

   assign w_rd_addr = AW'(r_count - CNT_W'(1));
   assign w_wr_addr = w_pop_ok ? w_rd_addr : r_count[AW-1:0];

   always_comb begin
      w_count_next = r_count;
      if (w_push_ok && !w_pop_ok)
         w_count_next = r_count + CNT_W'(1);
      else if (w_pop_ok && !w_push_ok)
         w_count_next = r_count - CNT_W'(1);
   end

   // Storage is deliberately not reset.
   always_ff @(posedge Clk) begin
      if (w_push_ok)
         r_mem[w_wr_addr] <= PushDataIn;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_count     <= '0;
         r_pop_data  <= '0;
         r_pop_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_udf       <= 1'b0;
      end else begin
         r_count     <= w_count_next;
         r_pop_valid <= w_pop_ok;
         if (w_pop_ok)
            r_pop_data <= r_mem[w_rd_addr];
         // A new error in the same cycle as ClrErr keeps the flag set.
         if (w_ovf_set)
            r_ovf <= 1'b1;
         else if (ClrErr)
            r_ovf <= 1'b0;
         if (w_udf_set)
            r_udf <= 1'b1;
         else if (ClrErr)
            r_udf <= 1'b0;
      end
   end

   assign PopDataOut  = r_pop_data;
   assign PopValid    = r_pop_valid;
   assign Count       = r_count;
   assign Stack_Full  = w_full;
   assign Stack_Empty = w_empty;
   assign Overflow    = r_ovf;
   assign Underflow   = r_udf;

`ifdef STACK_PEEK_EN
   assign TopData = w_empty ? '0 : r_mem[w_rd_addr];
`endif
endmodule
